// File: rtl/gate_selftest_pkg.sv
// Shared types and constants for the gate self-test slice: FSM states,
// vector count and the standard two-input truth tables.
package gate_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;

  // Bit i is the expected gate output for vector i = {B,A}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, with synchronous
// active-high reset clearing both stages.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_selftest.sv
// Sweeps a two-input gate through all four input vectors and checks its output
// against TRUTH. Define GATE_SELFTEST_LOOP_EN for continuous sticky-result looping.
module gate_selftest
  import gate_selftest_pkg::*;
#(
  parameter int         HOLD_CYCLES = 100,
  parameter logic [3:0] TRUTH       = TT_AND
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       A,
  output logic       B,
  input  logic       F,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_VEC
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [1:0]  LAST_VEC  = 2'(NUM_VEC - 1);

  state_t      state, state_nxt;
  logic [1:0]  vec_idx, vec_nxt;
  logic [15:0] hold_cnt, hold_nxt;
  logic [3:0]  fail_nxt;
  logic        f_sync;

  bit_sync u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (F),
    .q   (f_sync)
  );

  // The gate output is sampled only on the last hold cycle, so the
  // synchronizer delay has long settled by then.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_idx;
    hold_nxt  = hold_cnt;
    fail_nxt  = FAIL_VEC;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = DRIVE;
          vec_nxt   = 2'd0;
          hold_nxt  = 16'd0;
          fail_nxt  = 4'd0;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          if (f_sync != TRUTH[vec_idx]) fail_nxt[vec_idx] = 1'b1;
          hold_nxt = 16'd0;
          if (vec_idx == LAST_VEC) begin
            state_nxt = DONE_ST;
            vec_nxt   = 2'd0;
          end else begin
            vec_nxt = vec_idx + 2'd1;
          end
        end else begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      DONE_ST: begin
`ifdef GATE_SELFTEST_LOOP_EN
        state_nxt = DRIVE;
        vec_nxt   = 2'd0;
        hold_nxt  = 16'd0;
`else
        if (START) begin
          state_nxt = DRIVE;
          vec_nxt   = 2'd0;
          hold_nxt  = 16'd0;
          fail_nxt  = 4'd0;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they change in
  // the same cycle as the state and vector index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      vec_idx  <= 2'd0;
      hold_cnt <= 16'd0;
      FAIL_VEC <= 4'd0;
      A        <= 1'b0;
      B        <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
    end else begin
      state    <= state_nxt;
      vec_idx  <= vec_nxt;
      hold_cnt <= hold_nxt;
      FAIL_VEC <= fail_nxt;
      A        <= (state_nxt == DRIVE) && vec_nxt[0];
      B        <= (state_nxt == DRIVE) && vec_nxt[1];
      BUSY     <= (state_nxt == DRIVE);
      DONE     <= (state_nxt == DONE_ST);
      PASS     <= (state_nxt == DONE_ST) && (fail_nxt == 4'd0);
    end
  end

endmodule

// File: tb/tb_gate_selftest.sv
// Scoreboard bench for gate_selftest: two instances (AND and NAND truth tables)
// driven by a table-lookup gate model; sweep results checked against expectations.
module tb_gate_selftest;
  import gate_selftest_pkg::*;

  localparam int H     = 4;
  localparam int SWEEP = 4 * H;

  typedef struct {
    logic [3:0] fail;
    logic       pass;
    int         start_cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start_i [2];
  logic       a_o [2];
  logic       b_o [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       pass_o [2];
  logic [3:0] fvec_o [2];
  logic [3:0] f_tab [2];
  logic [3:0] acc [2];
  logic       f0, f1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // The gate under test is a 4-entry lookup indexed by {B,A}
  assign f0 = f_tab[0][{b_o[0], a_o[0]}];
  assign f1 = f_tab[1][{b_o[1], a_o[1]}];

  gate_selftest #(.HOLD_CYCLES(H), .TRUTH(TT_AND)) dut (
    .CLK(CLK), .RST(RST), .START(start_i[0]), .A(a_o[0]), .B(b_o[0]), .F(f0),
    .BUSY(busy_o[0]), .DONE(done_o[0]), .PASS(pass_o[0]), .FAIL_VEC(fvec_o[0])
  );

  gate_selftest #(.HOLD_CYCLES(H), .TRUTH(TT_NAND)) dut_nand (
    .CLK(CLK), .RST(RST), .START(start_i[1]), .A(a_o[1]), .B(b_o[1]), .F(f1),
    .BUSY(busy_o[1]), .DONE(done_o[1]), .PASS(pass_o[1]), .FAIL_VEC(fvec_o[1])
  );

  function automatic logic [3:0] truth_of(input int d);
    return (d == 0) ? TT_AND : TT_NAND;
  endfunction

  function automatic int q_size(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t q_front(input int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic q_clear(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected result of one sweep: any vector where the gate disagrees with
  // the truth table is a failing vector; loop mode keeps earlier failures.
  task automatic pushSweep(input int d, input logic [3:0] ftab, input int s);
    exp_t e;
`ifdef GATE_SELFTEST_LOOP_EN
    acc[d] = acc[d] | (ftab ^ truth_of(d));
`else
    acc[d] = ftab ^ truth_of(d);
`endif
    e.fail      = acc[d];
    e.pass      = (acc[d] == 4'd0);
    e.start_cyc = s;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input logic [3:0] ftab, input bit hold_start, output int s);
    @(posedge CLK); #2;
    f_tab[d]   = ftab;
    start_i[d] = 1'b1;
    s          = cyc + 1;
    pushSweep(d, ftab, s);
    if (!hold_start) begin
      @(posedge CLK); #2;
      start_i[d] = 1'b0;
    end
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge CLK); #2;
    end
  endtask

  task automatic waitDrain(input int d);
    int n = 0;
    while (q_size(d) > 0 && n < 3 * (SWEEP + 1) + 10) begin
      @(posedge CLK); #2;
      n++;
    end
    checkOutput($sformatf("d%0d_drain_pending", d), 32'(q_size(d)), 32'd0);
    q_clear(d);
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_d%0d_busy", tag, d), 32'(busy_o[d]), 32'd0);
      checkOutput($sformatf("%s_d%0d_done", tag, d), 32'(done_o[d]), 32'd0);
      checkOutput($sformatf("%s_d%0d_pass", tag, d), 32'(pass_o[d]), 32'd0);
      checkOutput($sformatf("%s_d%0d_failvec", tag, d), 32'(fvec_o[d]), 32'd0);
      checkOutput($sformatf("%s_d%0d_ab", tag, d), 32'({b_o[d], a_o[d]}), 32'd0);
    end
  endtask

  // Called at posedge+2; RST is sampled on the following edge.
  task automatic resetDut(input string tag);
    RST = 1'b1;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    @(posedge CLK); #1;
    q_clear(0);
    q_clear(1);
    acc[0] = 4'd0;
    acc[1] = 4'd0;
    #1 RST = 1'b0;
    @(negedge CLK);
    checkAllZero(tag);
    @(posedge CLK); #2;
  endtask

  task automatic monitorDut(input int d);
    exp_t e;
    int   k;
    bit   active = 1'b0;
    if (q_size(d) > 0) begin
      e = q_front(d);
      active = (cyc >= e.start_cyc);
    end
    if (active) begin
      k = cyc - e.start_cyc;
      if (k < SWEEP) begin
        checkOutput($sformatf("d%0d_busy_k%0d", d, k), 32'(busy_o[d]), 32'd1);
        checkOutput($sformatf("d%0d_vec_k%0d", d, k), 32'({b_o[d], a_o[d]}), 32'(k / H));
        checkOutput($sformatf("d%0d_done_k%0d", d, k), 32'(done_o[d]), 32'd0);
        checkOutput($sformatf("d%0d_pass_k%0d", d, k), 32'(pass_o[d]), 32'd0);
      end else begin
        checkOutput($sformatf("d%0d_done_at_latency", d), 32'(done_o[d]), 32'd1);
        checkOutput($sformatf("d%0d_busy_at_done", d), 32'(busy_o[d]), 32'd0);
        checkOutput($sformatf("d%0d_ab_at_done", d), 32'({b_o[d], a_o[d]}), 32'd0);
        checkOutput($sformatf("d%0d_pass", d), 32'(pass_o[d]), 32'(e.pass));
        checkOutput($sformatf("d%0d_failvec", d), 32'(fvec_o[d]), 32'(e.fail));
        q_pop(d);
      end
    end else begin
      checkOutput($sformatf("d%0d_idle_busy", d), 32'(busy_o[d]), 32'd0);
      checkOutput($sformatf("d%0d_idle_ab", d), 32'({b_o[d], a_o[d]}), 32'd0);
    end
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) monitorDut(d);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    logic [3:0] ft;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    f_tab[0]   = TT_AND;
    f_tab[1]   = TT_NAND;
    acc[0]     = 4'd0;
    acc[1]     = 4'd0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkAllZero("reset");
    @(posedge CLK); #2;
    RST = 1'b0;

`ifdef GATE_SELFTEST_LOOP_EN
    // V6: wrong gate on sweep 1 only; failures must stick across later sweeps
    ft = TT_AND ^ 4'($urandom_range(1, 15));
    $display("[TB] loop mode: sweep 1 gate table %b", ft);
    applyStimulus(0, ft, 1'b0, s);
    for (int n = 2; n <= 4; n++) begin
      waitCycle(s + SWEEP);
      f_tab[0] = TT_AND;
      s = s + SWEEP + 1;
      pushSweep(0, TT_AND, s);
    end
    waitCycle(s + SWEEP);
    resetDut("loop_end");
    repeat (3) @(posedge CLK);
    #2;
    applyStimulus(0, TT_AND, 1'b0, s);
    waitCycle(s + SWEEP);
    resetDut("loop_clean_end");
`else
    $display("[TB] V1: AND gate, AND truth table");
    applyStimulus(0, TT_AND, 1'b0, s);
    waitDrain(0);

    $display("[TB] V2: OR gate, AND truth table");
    applyStimulus(0, TT_OR, 1'b0, s);
    waitDrain(0);

    $display("[TB] V5: stuck-at-1 gate, NAND truth table");
    applyStimulus(1, 4'b1111, 1'b0, s);
    waitDrain(1);

    $display("[TB] V3: reset during vector 2");
    applyStimulus(0, TT_AND, 1'b0, s);
    waitCycle(s + 2 * H + 1);
    resetDut("midsweep");
    applyStimulus(0, TT_AND, 1'b0, s);
    waitDrain(0);

    $display("[TB] V4: START held through a sweep");
    applyStimulus(0, TT_OR, 1'b1, s);
    pushSweep(0, TT_OR, s + SWEEP + 1);
    waitCycle(s + SWEEP + 1);
    start_i[0] = 1'b0;
    waitDrain(0);

    $display("[TB] random gate tables");
    for (int n = 0; n < 8; n++) begin
      int d;
      d  = int'($urandom_range(0, 1));
      ft = 4'($urandom_range(0, 15));
      applyStimulus(d, ft, 1'b0, s);
      waitDrain(d);
    end
`endif

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_selftest.md
GATE_SELFTEST -- requirements
Module: gate_selftest

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 100: the number of CLK cycles each input vector is held (legal range 3 to 65535).
REQ-002 The block SHALL have parameter TRUTH, default 4'b1000: the expected F for vector index i={B,A}, read as TRUTH[i]. The default is AND.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-004 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port START, input, 1 bit: a request to start a sweep, sampled on the rising edge of CLK.
REQ-006 The block SHALL have ports A and B, outputs, 1 bit each, registered: the stimulus driven to the gate under test.
REQ-007 The block SHALL have port F, input, 1 bit: the gate-under-test output, which is asynchronous to CLK.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port DONE, output, 1 bit: high when a sweep has completed.
REQ-010 The block SHALL have port PASS, output, 1 bit: valid only while DONE=1; high when every vector matched.
REQ-011 The block SHALL have port FAIL_VEC, output, 4 bits: bit i is set when vector i mismatched.

Function
REQ-012 The FSM SHALL have exactly three states:
- IDLE
- DRIVE
- DONE_ST
REQ-013 In IDLE, START=1 SHALL cause the following on the next edge:
- FSM -> DRIVE
- vector index i=0
- hold counter = 0
- FAIL_VEC = 0
- BUSY = 1
REQ-014 Vector order SHALL be i=0,1,2,3, with A=i[0] and B=i[1], giving {A,B} = 00, 10, 01, 11.
REQ-015 A and B SHALL update in the same cycle that i updates, and SHALL be held constant for exactly HOLD_CYCLES cycles per vector.
REQ-016 F SHALL pass through a 2-flop synchronizer. The synchronized value SHALL be compared with TRUTH[i] in the cycle where hold counter = HOLD_CYCLES-1, and a mismatch SHALL set FAIL_VEC[i].
REQ-017 On the final hold cycle with i<3, the block SHALL increment i and clear the hold counter. With i=3, the FSM SHALL go to DONE_ST.
REQ-018 Total sweep latency SHALL be 4*HOLD_CYCLES+1 cycles from the START edge to DONE=1.
REQ-019 In DONE_ST the block SHALL drive:
- DONE = 1
- BUSY = 0
- A = 0, B = 0
- PASS = (FAIL_VEC == 0)
REQ-020 START SHALL be ignored while BUSY=1.
REQ-021 START in DONE_ST SHALL restart the sweep exactly as from IDLE, including clearing FAIL_VEC.
REQ-022 PASS SHALL be 0 whenever DONE=0.
REQ-023 The hold counter SHALL be 16 bits and SHALL never wrap, because it is cleared at HOLD_CYCLES-1.

Reset
REQ-024 RST=1 SHALL, at the next edge, force the following regardless of state, including mid-sweep:
- FSM = IDLE
- A = 0, B = 0
- BUSY = 0, DONE = 0, PASS = 0
- FAIL_VEC = 0
- i = 0, hold counter = 0
- synchronizer flops = 0
REQ-025 RST SHALL take priority over START when both are asserted in the same cycle.

Configuration
REQ-026 When macro GATE_SELFTEST_LOOP_EN is defined, DONE_ST SHALL last exactly one cycle before the block auto-restarts at i=0 without START.
REQ-027 With GATE_SELFTEST_LOOP_EN defined, FAIL_VEC SHALL NOT be cleared on restart, so it accumulates (sticky) until RST.
REQ-028 With GATE_SELFTEST_LOOP_EN defined, PASS SHALL reflect the accumulated FAIL_VEC during the DONE cycle.
REQ-029 When GATE_SELFTEST_LOOP_EN is undefined, the block SHALL remain in DONE_ST until START or RST.

Structure
REQ-030 Package gate_selftest_pkg SHALL hold:
- the state enum (IDLE, DRIVE, DONE_ST)
- constant NUM_VEC=4
- truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module named bit_sync, reused elsewhere on the kit.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- V1: HOLD_CYCLES=4, TRUTH=TT_AND, F modeled as A&B, one START pulse -> {A,B} sequence 00,10,01,11 with 4 cycles each; DONE=1 at cycle 17; PASS=1; FAIL_VEC=0000.
- V2: TRUTH=TT_AND, F modeled as A|B -> DONE=1; PASS=0; FAIL_VEC=0110.
- V3: RST pulsed for one cycle during vector 2 -> next cycle all outputs 0 and FSM=IDLE; a later START yields a full, clean sweep.
- V4: START held high throughout a sweep -> no restart until DONE_ST is reached; with the macro undefined, a new sweep begins the cycle after DONE.
- V5: F stuck at 1 with TRUTH=TT_NAND -> FAIL_VEC=1000, PASS=0.
- V6: GATE_SELFTEST_LOOP_EN defined, F forced wrong on sweep 1 only -> FAIL_VEC keeps the sweep-1 bits across later passing sweeps, and PASS=0 on every DONE pulse.
